// File: rtl/guess_game_param.sv
// guess_game_param: LFSR-seeded number guessing game with bitwise or higher/lower hints
module guess_game_param #(
  parameter int          WIDTH       = 6,
  parameter int          MAX_GUESSES = 3,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          HOLD_CYCLES = 8,
  localparam int         TW          = $clog2(MAX_GUESSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             guess_valid,
  input  logic [WIDTH-1:0] guess,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic             win,
  output logic             lose,
  output logic [TW-1:0]    tries_left
);
  localparam int          HW        = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [15:0] SEED_EFF  = SEED == 16'h0 ? 16'h0001 : SEED;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_GUESSES);

  typedef enum logic [1:0] {NEW, PLAY, WIN, LOSE} state_t;

  state_t           state, state_d;
  logic [15:0]      lfsr;
  logic             gv_q;
  logic [WIDTH-1:0] secret;
  logic [HW-1:0]    hold_cnt, hold_d;
  logic [WIDTH-1:0] result_d, hint, cmp;
  logic [TW-1:0]    tries_d;
  logic             win_d, lose_d;
  logic             accept, hit, last, hold_done, lo, hi;

  assign accept    = guess_valid & ~gv_q;
  assign hit       = guess == secret;
  assign last      = tries_left == TW'(1);
  assign hold_done = hold_cnt == '0;
  assign lo        = guess < secret;
  assign hi        = guess > secret;
  assign hint      = mode ? cmp : ~(guess ^ secret);

  if (WIDTH == 1) begin : g_cmp1
    assign cmp = lo;
  end else begin : g_cmpn
    assign cmp = WIDTH'({hi, lo});
  end

  // Free-running Galois LFSR and guess strobe history; reset blocks a held strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED_EFF;
      gv_q <= 1'b1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      gv_q <= guess_valid;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= NEW;
    else     state <= state_d;
  end

  // Next-state: NEW lasts one cycle, PLAY resolves on accepted guesses, WIN/LOSE time out
  always_comb begin
    state_d = state;
    unique case (state)
      NEW:     state_d = PLAY;
      PLAY:    state_d = accept ? (hit ? WIN : (last ? LOSE : PLAY)) : PLAY;
      default: state_d = hold_done ? NEW : state;
    endcase
  end

  // Next output values; leaving WIN/LOSE clears the outcome so win/lose track the state exactly
  always_comb begin
    result_d = result;
    win_d    = win;
    lose_d   = lose;
    tries_d  = tries_left;
    hold_d   = hold_cnt;
    unique case (state)
      NEW: begin
        result_d = '0;
        win_d    = 1'b0;
        lose_d   = 1'b0;
        tries_d  = TRIES_MAX;
      end
      PLAY: begin
        if (accept) begin
          hold_d   = HOLD_LOAD;
          result_d = hit ? '1 : (last ? secret : hint);
          win_d    = hit;
          lose_d   = ~hit & last;
          tries_d  = hit ? tries_left : tries_left - TW'(1);
        end
      end
      default: begin
        hold_d   = hold_done ? '0 : hold_cnt - HW'(1);
        result_d = hold_done ? '0 : result;
        win_d    = hold_done ? 1'b0 : win;
        lose_d   = hold_done ? 1'b0 : lose;
        tries_d  = hold_done ? TRIES_MAX : tries_left;
      end
    endcase
  end

  // Registered outputs, hold counter and the secret captured from the pre-advance LFSR in NEW
  always_ff @(posedge clk) begin
    if (rst) begin
      result     <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      tries_left <= '0;
      hold_cnt   <= '0;
      secret     <= '0;
    end else begin
      result     <= result_d;
      win        <= win_d;
      lose       <= lose_d;
      tries_left <= tries_d;
      hold_cnt   <= hold_d;
      if (state == NEW) secret <= lfsr[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_guess_game_param.sv
// tb_guess_game_param: directed scoreboard bench for guess_game_param
module tb_guess_game_param;
  localparam int          W  = 6;
  localparam int          MG = 3;
  localparam int          HC = 8;
  localparam logic [15:0] SD = 16'hACE1;

  typedef struct {
    logic [W-1:0] r;
    logic [1:0]   t;
    logic         w;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         guess_valid = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] guess = '0;
  logic [W-1:0] result;
  logic         win, lose;
  logic [1:0]   tries_left;
  logic [15:0]  m;
  logic [W-1:0] s;
  exp_t         sb[$];
  exp_t         e;
  int           vectors = 0;
  int           miscompares = 0;
  int           n;

  guess_game_param #(.WIDTH(W), .MAX_GUESSES(MG), .SEED(SD), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .guess_valid(guess_valid), .guess(guess), .mode(mode),
    .result(result), .win(win), .lose(lose), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) m <= rst ? SD : ({1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push(input logic [W-1:0] r, input logic [1:0] t, input logic w, input logic l);
    sb.push_back('{r, t, w, l});
  endtask

  task automatic pop_check(input string tag);
    e = sb.pop_front();
    chk({tag, ".result"}, 32'(result), 32'(e.r));
    chk({tag, ".tries"}, 32'(tries_left), 32'(e.t));
    chk({tag, ".win"}, 32'(win), 32'(e.w));
    chk({tag, ".lose"}, 32'(lose), 32'(e.l));
  endtask

  task automatic pulse(input string tag, input logic [W-1:0] g, input logic md,
                       input logic [W-1:0] r, input logic [1:0] t, input logic w, input logic l);
    guess = g;
    mode = md;
    guess_valid = 1'b1;
    push(r, t, w, l);
    @(negedge clk);
    pop_check(tag);
    guess_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic hold_count(input string tag, input int seen);
    n = seen;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(win || lose)) break;
      n++;
    end
    chk({tag, ".len"}, 32'(n), 32'(HC));
    push('0, 2'(MG), 1'b0, 1'b0);
    pop_check({tag, ".new"});
    s = m[W-1:0];
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push('0, 2'd0, 1'b0, 1'b0);
    pop_check(tag);
    rst = 1'b0;
    @(negedge clk);
    push('0, 2'(MG), 1'b0, 1'b0);
    pop_check({tag, ".idle"});
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset1");
    pulse("win_21", 6'h21, 1'b0, 6'h3F, 2'd3, 1'b1, 1'b0);
    hold_count("win_hold", 2);
    pulse("new_drop", s, 1'b0, 6'h00, 2'd3, 1'b0, 1'b0);
    pulse("win_lfsr", s, 1'b0, 6'h3F, 2'd3, 1'b1, 1'b0);
    pulse("win_ignore", s ^ 6'h01, 1'b0, 6'h3F, 2'd3, 1'b1, 1'b0);
    hold_count("win_hold2", 4);
    do_reset("reset2");
    pulse("bit_20", 6'h20, 1'b0, 6'h3E, 2'd2, 1'b0, 1'b0);
    pulse("hl_30", 6'h30, 1'b1, 6'h02, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    guess_valid = 1'b1;
    @(negedge clk);
    push('0, 2'd0, 1'b0, 1'b0);
    pop_check("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push('0, 2'd3, 1'b0, 1'b0);
      pop_check("held_gv");
    end
    guess_valid = 1'b0;
    @(negedge clk);
    pulse("hl_00", 6'h00, 1'b1, 6'h01, 2'd2, 1'b0, 1'b0);
    pulse("hl_3f", 6'h3F, 1'b1, 6'h02, 2'd1, 1'b0, 1'b0);
    pulse("lose", 6'h10, 1'b1, 6'h21, 2'd0, 1'b0, 1'b1);
    hold_count("lose_hold", 2);
    @(negedge clk);
    guess = s ^ 6'h01;
    mode = 1'b0;
    guess_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(6'h3E, 2'd2, 1'b0, 1'b0);
      @(negedge clk);
      pop_check("held5");
    end
    guess_valid = 1'b0;
    @(negedge clk);
    pulse("win_held", s, 1'b0, 6'h3F, 2'd2, 1'b1, 1'b0);
    pulse("win_ignore2", s ^ 6'h02, 1'b1, 6'h3F, 2'd2, 1'b1, 1'b0);
    hold_count("win_hold3", 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
